// File: rtl/freq_gate_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : freq_gate_sequencer
// Purpose  : Measurement sequencer for the frequency counter. Issues a clear
//            pulse and a gate window to the clk_x edge counter, waits out a
//            settle period, latches the count and offers it to the display
//            formatter over a valid/ready handshake.
// Options  : FREQ_AUTORANGE_EN - adapt the range per measurement, with
//            gate_sel_in acting as the maximum range.
// Revision : 1.0 - initial release
// ============================================================================
module freq_gate_sequencer #(
  parameter int COUNT_W       = 32,
  parameter int GATE_BASE     = 1000,
  parameter int SETTLE_CYCLES = 4,
  parameter int LOW_THRESH    = 1000
) (
  input  logic               clk_ref_in,
  input  logic               reset_in,
  input  logic               enable_in,
  input  logic [1:0]         gate_sel_in,
  output logic               cnt_clear_out,
  output logic               cnt_gate_out,
  input  logic [COUNT_W-1:0] cnt_value_in,
  input  logic               cnt_ovf_in,
  output logic [COUNT_W-1:0] result_out,
  output logic [1:0]         result_range_out,
  output logic               result_ovf_out,
  output logic               result_valid_out,
  input  logic               result_ready_in,
  output logic               busy_out
);

  // The cycle counter times both the gate (GATE_BASE cycles per decade) and
  // the settle period, so it is sized for the larger of the two.
  localparam int CYC_MAX = (GATE_BASE > SETTLE_CYCLES) ? GATE_BASE : SETTLE_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_GATE   = 3'd2,
    S_SETTLE = 3'd3,
    S_LATCH  = 3'd4,
    S_HOLD   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [9:0]           dec_q, dec_d;
  logic [1:0]           range_q, range_d;
  logic [COUNT_W-1:0]   result_q, result_d;
  logic [1:0]           res_range_q, res_range_d;
  logic                 res_ovf_q, res_ovf_d;
  logic [1:0]           arm_range;

  // Number of extra decades (10^range - 1) the gate spans beyond the first.
  function automatic logic [9:0] decade_load(input logic [1:0] r);
    case (r)
      2'd0:    decade_load = 10'd0;
      2'd1:    decade_load = 10'd9;
      2'd2:    decade_load = 10'd99;
      default: decade_load = 10'd999;
    endcase
  endfunction

`ifdef FREQ_AUTORANGE_EN
  logic [1:0] auto_q, auto_d;

  // Range proposed for the next ARM, capped by the requested maximum range.
  always_comb begin
    arm_range = (auto_q > gate_sel_in) ? gate_sel_in : auto_q;
  end
`else
  // Without autoranging the requested range is used directly.
  always_comb begin
    arm_range = gate_sel_in;
  end
`endif

  // Next-state and datapath updates for the measurement sequence.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    dec_d       = dec_q;
    range_d     = range_q;
    result_d    = result_q;
    res_range_d = res_range_q;
    res_ovf_d   = res_ovf_q;
`ifdef FREQ_AUTORANGE_EN
    auto_d      = auto_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef FREQ_AUTORANGE_EN
        // Every fresh run starts from the requested range.
        auto_d = gate_sel_in;
`endif
        if (enable_in) state_d = S_ARM;
      end
      S_ARM: begin
        range_d = arm_range;
        cyc_d   = CYC_W'(GATE_BASE - 1);
        dec_d   = decade_load(arm_range);
        state_d = S_GATE;
      end
      S_GATE: begin
        if (cyc_q == '0) begin
          if (dec_q == '0) begin
            // Settle timing reuses the cycle counter.
            cyc_d   = CYC_W'(SETTLE_CYCLES - 1);
            state_d = S_SETTLE;
          end else begin
            cyc_d = CYC_W'(GATE_BASE - 1);
            dec_d = dec_q - 10'd1;
          end
        end else begin
          cyc_d = cyc_q - CYC_W'(1);
        end
      end
      S_SETTLE: begin
        if (cyc_q == '0) state_d = S_LATCH;
        else             cyc_d   = cyc_q - CYC_W'(1);
      end
      S_LATCH: begin
        result_d    = cnt_value_in;
        res_ovf_d   = cnt_ovf_in;
        res_range_d = range_q;
`ifdef FREQ_AUTORANGE_EN
        if (cnt_ovf_in && (range_q != 2'd0))
          auto_d = range_q - 2'd1;
        else if (!cnt_ovf_in && (cnt_value_in < COUNT_W'(LOW_THRESH)) &&
                 (range_q < gate_sel_in))
          auto_d = range_q + 2'd1;
        else
          auto_d = range_q;
`endif
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (result_ready_in) state_d = enable_in ? S_ARM : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any measurement in progress.
  always_ff @(posedge clk_ref_in) begin
    if (reset_in) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      dec_q       <= '0;
      range_q     <= '0;
      result_q    <= '0;
      res_range_q <= '0;
      res_ovf_q   <= 1'b0;
`ifdef FREQ_AUTORANGE_EN
      auto_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      dec_q       <= dec_d;
      range_q     <= range_d;
      result_q    <= result_d;
      res_range_q <= res_range_d;
      res_ovf_q   <= res_ovf_d;
`ifdef FREQ_AUTORANGE_EN
      auto_q      <= auto_d;
`endif
    end
  end

  // Control outputs decode directly from the registered state.
  always_comb begin
    cnt_clear_out    = (state_q == S_ARM);
    cnt_gate_out     = (state_q == S_GATE);
    result_valid_out = (state_q == S_HOLD);
    busy_out         = (state_q != S_IDLE);
    result_out       = result_q;
    result_range_out = res_range_q;
    result_ovf_out   = res_ovf_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_gate_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_gate_sequencer
// Purpose  : Directed self-checking bench for freq_gate_sequencer
//            (GATE_BASE=10, SETTLE_CYCLES=2, COUNT_W=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_gate_sequencer;

  localparam int COUNT_W = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic [1:0]         sel = 2'd0;
  logic               clr, gate, rovf, valid, busy, ready = 1'b0;
  logic [COUNT_W-1:0] val = '0, res;
  logic               ovf = 1'b0;
  logic [1:0]         rng;

  int tests = 0;
  int fails = 0;

  freq_gate_sequencer #(
    .COUNT_W(COUNT_W), .GATE_BASE(10), .SETTLE_CYCLES(2), .LOW_THRESH(1000)
  ) dut (
    .clk_ref_in(clk), .reset_in(rst), .enable_in(en), .gate_sel_in(sel),
    .cnt_clear_out(clr), .cnt_gate_out(gate), .cnt_value_in(val),
    .cnt_ovf_in(ovf), .result_out(res), .result_range_out(rng),
    .result_ovf_out(rovf), .result_valid_out(valid),
    .result_ready_in(ready), .busy_out(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       sig = clr;
      1:       sig = gate;
      2:       sig = valid;
      default: sig = busy;
    endcase
  endfunction

  task automatic wait_sig(input int w, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (sig(w)) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic count_high(input int w, input int max_cyc, output int n);
    n = 0;
    while (sig(w) && n < max_cyc) begin n++; step(); end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ready = 1'b0; ovf = 1'b0; sel = 2'd0; val = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; val = 16'hBEEF; ovf = 1'b1; ready = 1'b1;
    step(); step();
    tests++; if ({clr, gate, valid, busy} !== 4'b0) begin fails++;
      $display("FAIL reset_ctrl: got %b expected 0000", {clr, gate, valid, busy}); end
    tests++; if (res !== '0) begin fails++;
      $display("FAIL reset_result: got %h expected 0000", res); end
    tests++; if ({rng, rovf} !== 3'b0) begin fails++;
      $display("FAIL reset_range_ovf: got %b expected 000", {rng, rovf}); end
  endtask

  task automatic test_basic();
    bit ok; int n, k;
    do_reset();
    en = 1'b1; sel = 2'd0; ready = 1'b1; val = 16'd123;
    wait_sig(0, 10, ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_clear: got none expected pulse"); end
    step();
    tests++; if ({clr, gate} !== 2'b01) begin fails++;
      $display("FAIL basic_clear_width: got clr,gate=%b expected 01", {clr, gate}); end
    count_high(1, 2000, n);
    tests++; if (n != 10) begin fails++; $display("FAIL basic_gate_len: got %0d expected 10", n); end
    k = 0;
    while (!valid && k < 20) begin k++; step(); end
    tests++; if (k != 3) begin fails++; $display("FAIL basic_valid_delay: got %0d expected 3", k); end
    tests++; if ({res, rng, rovf} !== {16'd123, 2'd0, 1'b0}) begin fails++;
      $display("FAIL basic_result: got %0d/%0d/%0d expected 123/0/0", res, rng, rovf); end
    step();
    tests++; if ({valid, clr} !== 2'b01) begin fails++;
      $display("FAIL basic_next_clear: got valid,clr=%b expected 01", {valid, clr}); end
  endtask

  task automatic test_range2();
    bit ok; int n;
    do_reset();
    en = 1'b1; sel = 2'd2; ready = 1'b1; val = 16'd9;
    wait_sig(1, 10, ok);
    n = 0;
    while (gate && n < 2000) begin
      if (n == 500) sel = 2'd0;
      n++; step();
    end
    tests++; if (n != 1000) begin fails++; $display("FAIL range2_gate_len: got %0d expected 1000", n); end
    wait_sig(2, 10, ok);
    tests++; if (!ok || rng !== 2'd2) begin fails++;
      $display("FAIL range2_range: got %0d (valid %0d) expected 2", rng, ok); end
    step(); step();
    count_high(1, 2000, n);
    tests++; if (n != 10) begin fails++; $display("FAIL range2_next_gate: got %0d expected 10", n); end
    wait_sig(2, 10, ok);
    tests++; if (!ok || rng !== 2'd0) begin fails++;
      $display("FAIL range2_next_range: got %0d expected 0", rng); end
  endtask

  task automatic test_backpressure();
    bit ok; bit bad;
    do_reset();
    en = 1'b1; sel = 2'd0; ready = 1'b0; val = 16'd456;
    wait_sig(2, 50, ok);
    tests++; if (!ok) begin fails++; $display("FAIL bp_valid: got none expected valid"); end
    val = 16'd999;
    bad = 1'b0;
    repeat (50) begin
      if (!valid || res !== 16'd456 || clr || !busy) bad = 1'b1;
      step();
    end
    tests++; if (bad) begin fails++;
      $display("FAIL bp_hold: got unstable hold (valid=%0d res=%0d) expected 1/456", valid, res); end
    ready = 1'b1;
    step();
    tests++; if ({valid, clr} !== 2'b01) begin fails++;
      $display("FAIL bp_transfer: got valid,clr=%b expected 01", {valid, clr}); end
    step();
    tests++; if ({valid, gate} !== 2'b01) begin fails++;
      $display("FAIL bp_single: got valid,gate=%b expected 01", {valid, gate}); end
  endtask

  task automatic test_enable_drop();
    bit ok; bit bad; int n;
    do_reset();
    en = 1'b1; sel = 2'd1; ready = 1'b1; val = 16'd77; ovf = 1'b1;
    wait_sig(1, 10, ok);
    n = 0;
    while (gate && n < 2000) begin
      if (n == 5) en = 1'b0;
      n++; step();
    end
    tests++; if (n != 100) begin fails++; $display("FAIL drop_gate_len: got %0d expected 100", n); end
    wait_sig(2, 10, ok);
    tests++; if (!ok || res !== 16'd77 || rovf !== 1'b1 || rng !== 2'd1) begin fails++;
      $display("FAIL drop_result: got %0d/%0d/%0d expected 77/1/1", res, rovf, rng); end
    step();
    bad = 1'b0;
    repeat (10) begin
      if (busy || clr || valid) bad = 1'b1;
      step();
    end
    tests++; if (bad) begin fails++; $display("FAIL drop_idle: got activity expected idle busy=0"); end
  endtask

  task automatic test_reset_mid();
    bit ok; bit bad;
    do_reset();
    en = 1'b1; sel = 2'd0; ready = 1'b0; val = 16'd55; ovf = 1'b1;
    wait_sig(2, 50, ok);
    tests++; if (!ok || res !== 16'd55) begin fails++;
      $display("FAIL rmid_pre: got %0d expected 55", res); end
    rst = 1'b1; en = 1'b0;
    step();
    tests++; if ({clr, gate, valid, busy, rovf, rng, res} !== '0) begin fails++;
      $display("FAIL rmid_hold_reset: got c%0d g%0d v%0d b%0d o%0d r%0d res%0d expected all 0",
               clr, gate, valid, busy, rovf, rng, res); end
    rst = 1'b0;
    bad = 1'b0;
    repeat (5) begin if (busy || clr) bad = 1'b1; step(); end
    tests++; if (bad) begin fails++; $display("FAIL rmid_no_start: got start expected idle"); end
    en = 1'b1;
    wait_sig(1, 10, ok);
    step(); step(); step();
    rst = 1'b1; en = 1'b0;
    step();
    tests++; if ({clr, gate, valid, busy, rovf, rng, res} !== '0) begin fails++;
      $display("FAIL rmid_gate_reset: got c%0d g%0d v%0d b%0d o%0d r%0d res%0d expected all 0",
               clr, gate, valid, busy, rovf, rng, res); end
    rst = 1'b0;
    bad = 1'b0;
    repeat (20) begin if (busy || gate) bad = 1'b1; step(); end
    tests++; if (bad) begin fails++; $display("FAIL rmid_gate_idle: got activity expected idle"); end
  endtask

`ifdef FREQ_AUTORANGE_EN
  task automatic test_autorange();
    bit ok; int n;
    do_reset();
    en = 1'b1; sel = 2'd3; ready = 1'b1; ovf = 1'b1; val = 16'd0;
    wait_sig(1, 10, ok);
    count_high(1, 20000, n);
    tests++; if (n != 10000) begin fails++; $display("FAIL auto_first_gate: got %0d expected 10000", n); end
    wait_sig(2, 10, ok);
    ovf = 1'b0; val = 16'd5;
    step(); step();
    count_high(1, 20000, n);
    tests++; if (n != 1000) begin fails++; $display("FAIL auto_down_gate: got %0d expected 1000", n); end
    wait_sig(2, 10, ok);
    tests++; if (rng !== 2'd2) begin fails++; $display("FAIL auto_down_range: got %0d expected 2", rng); end
    step(); step();
    count_high(1, 20000, n);
    tests++; if (n != 10000) begin fails++; $display("FAIL auto_up_gate: got %0d expected 10000", n); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_range2();
    test_backpressure();
    test_enable_drop();
    test_reset_mid();
`ifdef FREQ_AUTORANGE_EN
    test_autorange();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
